// File: rtl/add_serial_pkg.sv
// Shared types and default constants for the bit-serial adder scheduler.
package add_serial_pkg;

  localparam int ADD_W       = 8;
  localparam int ADD_LATENCY = 9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/add_serial_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around to the lower indices.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  id
);

  int idx;

  // NOTE: every variable gets a default before any branch, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters;
// sequences the adder and returns id-tagged sums over a valid/ready port.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = ADD_W,
  parameter int LATENCY = ADD_LATENCY,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  add_en,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(LATENCY);

  sched_state_t     state, state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [CNT_W-1:0] cnt;
  logic             arb_valid;
  logic [IDW-1:0]   arb_id;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .valid (arb_valid),
    .id    (arb_id)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt        = '0;
    add_en     = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (arb_valid) state_next = ISSUE;
      ISSUE: begin
        gnt        = NREQ'(1) << id;
        add_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (cnt == '0) state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are only reloaded on a new pick in IDLE, so they stay put from
  // ISSUE until the response has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id      <= '0;
      ptr     <= '0;
      cnt     <= '0;
      add_a   <= '0;
      add_b   <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            id    <= arb_id;
            add_a <= req_a[int'(arb_id)*WIDTH +: WIDTH];
            add_b <= req_b[int'(arb_id)*WIDTH +: WIDTH];
          end
        end
        ISSUE: begin
          ptr <= (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
          cnt <= CNT_W'(LATENCY-1);
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_sum <= add_out;
            rsp_id  <= id;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
